// File: rtl/write_channel_arbiter.sv
// -----------------------------------------------------------------------------
// write_channel_arbiter
//
// Purpose
//   This module shares one AXI write channel (AW, W and B) between two masters,
//   M0 and M1. Only one transaction is in flight at a time. A transaction moves
//   through four phases:
//     IDLE -> ADDR -> DATA -> RESP -> IDLE
//   In IDLE the arbiter picks a winner and registers the grant. In ADDR, DATA
//   and RESP the granted master is routed through to the slave. The other
//   master sees every READY and BVALID held at 0.
//
//   The arbiter also counts W beats. When the beat count reaches the AWLEN that
//   was captured in ADDR, that beat is treated as the last beat, even if the
//   master never raises WLAST.
//
// Configuration
//   AXI_WARB_RR_EN  When defined, simultaneous requests are resolved round-robin.
//                   A pointer prefers the master that was not served last.
//                   When undefined, M0 has fixed priority and there is no
//                   pointer register.
//
// Ports
//   ACLK, ARESETn            clock; asynchronous active-low reset
//   AW*_Mx, W*_Mx            AW / W request channels from master x (x = 0, 1)
//   AWREADY_Mx, WREADY_Mx    handshakes back to master x (granted master only)
//   BID_Mx, BRESP_Mx,
//   BVALID_Mx, BREADY_Mx     write response to master x
//   AW*_ARB, W*_ARB,
//   BREADY_ARB               channel towards the slave
//   AWREADY_ARB, WREADY_ARB,
//   BID_ARB, BRESP_ARB,
//   BVALID_ARB               handshakes and response from the slave
//   GRANT_M0, GRANT_M1       high from ADDR through RESP for the owner
// -----------------------------------------------------------------------------
module write_channel_arbiter #(
  parameter int unsigned AXI_ID_BITS   = 4,
  parameter int unsigned AXI_ADDR_BITS = 32,
  parameter int unsigned AXI_LEN_BITS  = 4,
  parameter int unsigned AXI_SIZE_BITS = 3,
  parameter int unsigned AXI_DATA_BITS = 32,
  parameter int unsigned AXI_STRB_BITS = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,

  // Master 0
  input  logic [AXI_ID_BITS-1:0]   AWID_M0,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR_M0,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN_M0,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE_M0,
  input  logic [1:0]               AWBURST_M0,
  input  logic                     AWVALID_M0,
  output logic                     AWREADY_M0,
  input  logic [AXI_DATA_BITS-1:0] WDATA_M0,
  input  logic [AXI_STRB_BITS-1:0] WSTRB_M0,
  input  logic                     WLAST_M0,
  input  logic                     WVALID_M0,
  output logic                     WREADY_M0,
  output logic [AXI_ID_BITS-1:0]   BID_M0,
  output logic [1:0]               BRESP_M0,
  output logic                     BVALID_M0,
  input  logic                     BREADY_M0,

  // Master 1
  input  logic [AXI_ID_BITS-1:0]   AWID_M1,
  input  logic [AXI_ADDR_BITS-1:0] AWADDR_M1,
  input  logic [AXI_LEN_BITS-1:0]  AWLEN_M1,
  input  logic [AXI_SIZE_BITS-1:0] AWSIZE_M1,
  input  logic [1:0]               AWBURST_M1,
  input  logic                     AWVALID_M1,
  output logic                     AWREADY_M1,
  input  logic [AXI_DATA_BITS-1:0] WDATA_M1,
  input  logic [AXI_STRB_BITS-1:0] WSTRB_M1,
  input  logic                     WLAST_M1,
  input  logic                     WVALID_M1,
  output logic                     WREADY_M1,
  output logic [AXI_ID_BITS-1:0]   BID_M1,
  output logic [1:0]               BRESP_M1,
  output logic                     BVALID_M1,
  input  logic                     BREADY_M1,

  // Slave side
  output logic [AXI_ID_BITS-1:0]   AWID_ARB,
  output logic [AXI_ADDR_BITS-1:0] AWADDR_ARB,
  output logic [AXI_LEN_BITS-1:0]  AWLEN_ARB,
  output logic [AXI_SIZE_BITS-1:0] AWSIZE_ARB,
  output logic [1:0]               AWBURST_ARB,
  output logic                     AWVALID_ARB,
  input  logic                     AWREADY_ARB,
  output logic [AXI_DATA_BITS-1:0] WDATA_ARB,
  output logic [AXI_STRB_BITS-1:0] WSTRB_ARB,
  output logic                     WLAST_ARB,
  output logic                     WVALID_ARB,
  input  logic                     WREADY_ARB,
  input  logic [AXI_ID_BITS-1:0]   BID_ARB,
  input  logic [1:0]               BRESP_ARB,
  input  logic                     BVALID_ARB,
  output logic                     BREADY_ARB,

  // Status
  output logic                     GRANT_M0,
  output logic                     GRANT_M1
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e                  state_q,    state_d;
  logic                    grant_m0_q, grant_m0_d;
  logic                    grant_m1_q, grant_m1_d;
  logic [AXI_LEN_BITS:0]   beat_cnt_q, beat_cnt_d;
  logic [AXI_LEN_BITS-1:0] len_q,      len_d;

  // Selected-master view of the request channels
  logic                     sel_m1;
  logic [AXI_ID_BITS-1:0]   g_awid;
  logic [AXI_ADDR_BITS-1:0] g_awaddr;
  logic [AXI_LEN_BITS-1:0]  g_awlen;
  logic [AXI_SIZE_BITS-1:0] g_awsize;
  logic [1:0]               g_awburst;
  logic                     g_awvalid;
  logic [AXI_DATA_BITS-1:0] g_wdata;
  logic [AXI_STRB_BITS-1:0] g_wstrb;
  logic                     g_wlast;
  logic                     g_wvalid;
  logic                     g_bready;

  logic                     pick_m1;
  logic                     aw_hs;
  logic                     w_hs;
  logic                     b_hs;
  logic                     last_beat;

  // The mux select comes from the registered grant. Nothing reaches the
  // slave in the cycle a request first appears.
  assign sel_m1 = grant_m1_q;

  always_comb begin
    if (sel_m1) begin
      g_awid    = AWID_M1;
      g_awaddr  = AWADDR_M1;
      g_awlen   = AWLEN_M1;
      g_awsize  = AWSIZE_M1;
      g_awburst = AWBURST_M1;
      g_awvalid = AWVALID_M1;
      g_wdata   = WDATA_M1;
      g_wstrb   = WSTRB_M1;
      g_wlast   = WLAST_M1;
      g_wvalid  = WVALID_M1;
      g_bready  = BREADY_M1;
    end else begin
      g_awid    = AWID_M0;
      g_awaddr  = AWADDR_M0;
      g_awlen   = AWLEN_M0;
      g_awsize  = AWSIZE_M0;
      g_awburst = AWBURST_M0;
      g_awvalid = AWVALID_M0;
      g_wdata   = WDATA_M0;
      g_wstrb   = WSTRB_M0;
      g_wlast   = WLAST_M0;
      g_wvalid  = WVALID_M0;
      g_bready  = BREADY_M0;
    end
  end

  // Winner selection. It is only used in IDLE.
`ifdef AXI_WARB_RR_EN
  // rr_ptr_q = 1 means M1 is preferred when both masters request.
  logic rr_ptr_q, rr_ptr_d;
  assign pick_m1 = AWVALID_M1 & (~AWVALID_M0 | rr_ptr_q);
`else
  assign pick_m1 = AWVALID_M1 & ~AWVALID_M0;
`endif

  assign aw_hs     = (state_q == ST_ADDR) & g_awvalid & AWREADY_ARB;
  assign w_hs      = (state_q == ST_DATA) & g_wvalid  & WREADY_ARB;
  assign b_hs      = (state_q == ST_RESP) & BVALID_ARB & g_bready;
  // The captured AWLEN closes the burst even when the master forgets WLAST.
  assign last_beat = g_wlast | (beat_cnt_q == {1'b0, len_q});

  // Next-state logic
  always_comb begin
    // NOTE: every next-state signal is given its held value first. Paths that
    // do not assign a signal then cannot infer a latch.
    state_d    = state_q;
    grant_m0_d = grant_m0_q;
    grant_m1_d = grant_m1_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
`ifdef AXI_WARB_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        beat_cnt_d = '0;
        if (AWVALID_M0 | AWVALID_M1) begin
          state_d    = ST_ADDR;
          grant_m0_d = ~pick_m1;
          grant_m1_d = pick_m1;
        end
      end

      // A master that drops AWVALID here keeps its grant. The FSM waits in
      // ADDR for the handshake.
      ST_ADDR: begin
        if (aw_hs) begin
          state_d    = ST_DATA;
          len_d      = g_awlen;
          beat_cnt_d = '0;
        end
      end

      ST_DATA: begin
        if (w_hs) begin
          if (last_beat) begin
            state_d = ST_RESP;
          end else begin
            beat_cnt_d = beat_cnt_q + (AXI_LEN_BITS+1)'(1);
          end
        end
      end

      ST_RESP: begin
        if (b_hs) begin
          state_d    = ST_IDLE;
          grant_m0_d = 1'b0;
          grant_m1_d = 1'b0;
`ifdef AXI_WARB_RR_EN
          // The master just served loses priority for the next tie.
          rr_ptr_d   = ~grant_m1_q;
`endif
        end
      end

      default: begin
        state_d    = ST_IDLE;
        grant_m0_d = 1'b0;
        grant_m1_d = 1'b0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= ST_IDLE;
      grant_m0_q <= 1'b0;
      grant_m1_q <= 1'b0;
      beat_cnt_q <= '0;
      len_q      <= '0;
`ifdef AXI_WARB_RR_EN
      rr_ptr_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here. All registers then update
      // together from the values they held before the edge.
      state_q    <= state_d;
      grant_m0_q <= grant_m0_d;
      grant_m1_q <= grant_m1_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
`ifdef AXI_WARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  assign GRANT_M0 = grant_m0_q;
  assign GRANT_M1 = grant_m1_q;

  // Output routing. Each channel is opened only in its own phase.
  // Everything is 0 in IDLE, and during reset because state_q is then IDLE.
  always_comb begin
    AWID_ARB    = '0;
    AWADDR_ARB  = '0;
    AWLEN_ARB   = '0;
    AWSIZE_ARB  = '0;
    AWBURST_ARB = '0;
    AWVALID_ARB = 1'b0;
    WDATA_ARB   = '0;
    WSTRB_ARB   = '0;
    WLAST_ARB   = 1'b0;
    WVALID_ARB  = 1'b0;
    BREADY_ARB  = 1'b0;
    AWREADY_M0  = 1'b0;
    AWREADY_M1  = 1'b0;
    WREADY_M0   = 1'b0;
    WREADY_M1   = 1'b0;
    BID_M0      = '0;
    BID_M1      = '0;
    BRESP_M0    = '0;
    BRESP_M1    = '0;
    BVALID_M0   = 1'b0;
    BVALID_M1   = 1'b0;

    unique case (state_q)
      ST_ADDR: begin
        AWID_ARB    = g_awid;
        AWADDR_ARB  = g_awaddr;
        AWLEN_ARB   = g_awlen;
        AWSIZE_ARB  = g_awsize;
        AWBURST_ARB = g_awburst;
        AWVALID_ARB = g_awvalid;
        AWREADY_M0  = ~sel_m1 & AWREADY_ARB;
        AWREADY_M1  =  sel_m1 & AWREADY_ARB;
      end

      ST_DATA: begin
        WDATA_ARB   = g_wdata;
        WSTRB_ARB   = g_wstrb;
        WLAST_ARB   = last_beat;
        WVALID_ARB  = g_wvalid;
        WREADY_M0   = ~sel_m1 & WREADY_ARB;
        WREADY_M1   =  sel_m1 & WREADY_ARB;
      end

      ST_RESP: begin
        BREADY_ARB  = g_bready;
        if (sel_m1) begin
          BID_M1    = BID_ARB;
          BRESP_M1  = BRESP_ARB;
          BVALID_M1 = BVALID_ARB;
        end else begin
          BID_M0    = BID_ARB;
          BRESP_M0  = BRESP_ARB;
          BVALID_M0 = BVALID_ARB;
        end
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_write_channel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_write_channel_arbiter
//
// Purpose
//   This is a directed bench for write_channel_arbiter.
//
//   A table of per-cycle vectors walks through two transactions:
//     - M0 with AWLEN=3 and a W stall;
//     - M1 with AWLEN=1 and no WLAST, including an AW stall and a dropped
//       AWVALID.
//   Hand-written sequences then cover these multi-cycle corners:
//     - simultaneous requests;
//     - a request that arrives mid-transaction;
//     - reset asserted mid-burst;
//     - slave AW and B stalls.
//
//   Inputs are driven on the falling edge. Outputs are sampled 1-2 time units
//   later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_write_channel_arbiter;

  localparam logic [3:0]  M0_ID   = 4'h3;
  localparam logic [31:0] M0_ADDR = 32'h0000_1000;
  localparam logic [3:0]  M0_LEN  = 4'd3;
  localparam logic [31:0] M0_DATA = 32'hDEAD_0000;
  localparam logic [3:0]  M1_ID   = 4'h5;
  localparam logic [31:0] M1_ADDR = 32'h0000_2000;
  localparam logic [3:0]  M1_LEN  = 4'd1;
  localparam logic [31:0] M1_DATA = 32'hBEEF_0001;
  localparam logic [3:0]  S_BID   = 4'h9;

  logic ACLK = 1'b0;
  logic ARESETn;
  always #5 ACLK = ~ACLK;

  logic [3:0]  AWID_M0, AWID_M1, AWLEN_M0, AWLEN_M1;
  logic [31:0] AWADDR_M0, AWADDR_M1, WDATA_M0, WDATA_M1;
  logic [2:0]  AWSIZE_M0, AWSIZE_M1;
  logic [1:0]  AWBURST_M0, AWBURST_M1;
  logic [3:0]  WSTRB_M0, WSTRB_M1;
  logic        AWVALID_M0, AWVALID_M1, WLAST_M0, WLAST_M1, WVALID_M0, WVALID_M1;
  logic        BREADY_M0, BREADY_M1;
  logic        AWREADY_M0, AWREADY_M1, WREADY_M0, WREADY_M1, BVALID_M0, BVALID_M1;
  logic [3:0]  BID_M0, BID_M1;
  logic [1:0]  BRESP_M0, BRESP_M1;
  logic [3:0]  AWID_ARB, AWLEN_ARB, WSTRB_ARB;
  logic [31:0] AWADDR_ARB, WDATA_ARB;
  logic [2:0]  AWSIZE_ARB;
  logic [1:0]  AWBURST_ARB;
  logic        AWVALID_ARB, WLAST_ARB, WVALID_ARB, BREADY_ARB;
  logic        AWREADY_ARB, WREADY_ARB, BVALID_ARB;
  logic [3:0]  BID_ARB;
  logic [1:0]  BRESP_ARB;
  logic        GRANT_M0, GRANT_M1;

  write_channel_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_M0(AWID_M0), .AWADDR_M0(AWADDR_M0), .AWLEN_M0(AWLEN_M0),
    .AWSIZE_M0(AWSIZE_M0), .AWBURST_M0(AWBURST_M0), .AWVALID_M0(AWVALID_M0),
    .AWREADY_M0(AWREADY_M0), .WDATA_M0(WDATA_M0), .WSTRB_M0(WSTRB_M0),
    .WLAST_M0(WLAST_M0), .WVALID_M0(WVALID_M0), .WREADY_M0(WREADY_M0),
    .BID_M0(BID_M0), .BRESP_M0(BRESP_M0), .BVALID_M0(BVALID_M0), .BREADY_M0(BREADY_M0),
    .AWID_M1(AWID_M1), .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1),
    .AWSIZE_M1(AWSIZE_M1), .AWBURST_M1(AWBURST_M1), .AWVALID_M1(AWVALID_M1),
    .AWREADY_M1(AWREADY_M1), .WDATA_M1(WDATA_M1), .WSTRB_M1(WSTRB_M1),
    .WLAST_M1(WLAST_M1), .WVALID_M1(WVALID_M1), .WREADY_M1(WREADY_M1),
    .BID_M1(BID_M1), .BRESP_M1(BRESP_M1), .BVALID_M1(BVALID_M1), .BREADY_M1(BREADY_M1),
    .AWID_ARB(AWID_ARB), .AWADDR_ARB(AWADDR_ARB), .AWLEN_ARB(AWLEN_ARB),
    .AWSIZE_ARB(AWSIZE_ARB), .AWBURST_ARB(AWBURST_ARB), .AWVALID_ARB(AWVALID_ARB),
    .AWREADY_ARB(AWREADY_ARB), .WDATA_ARB(WDATA_ARB), .WSTRB_ARB(WSTRB_ARB),
    .WLAST_ARB(WLAST_ARB), .WVALID_ARB(WVALID_ARB), .WREADY_ARB(WREADY_ARB),
    .BID_ARB(BID_ARB), .BRESP_ARB(BRESP_ARB), .BVALID_ARB(BVALID_ARB),
    .BREADY_ARB(BREADY_ARB), .GRANT_M0(GRANT_M0), .GRANT_M1(GRANT_M1)
  );

  // Control-output bundle, in the bit order used by the vector table.
  wire [11:0] ctrl_act = {AWVALID_ARB, AWREADY_M0, AWREADY_M1, WVALID_ARB,
                          WLAST_ARB, WREADY_M0, WREADY_M1, BVALID_M0,
                          BVALID_M1, BREADY_ARB, GRANT_M0, GRANT_M1};
  wire [63:0] bus_act  = {AWADDR_ARB, WDATA_ARB};
  wire [28:0] misc_act = {AWID_ARB, AWLEN_ARB, AWSIZE_ARB, AWBURST_ARB, WSTRB_ARB,
                          BID_M0, BID_M1, BRESP_M0, BRESP_M1};

  // in   = {av0, av1, wv0, wl0, wv1, wl1, awready, wready, bvalid, br0, br1}
  // ctrl = bit order of ctrl_act
  typedef struct {
    logic [10:0] in;
    logic [11:0] ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  logic bad;
  logic [1:0] exp_second;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    AWVALID_M0 = 0; AWVALID_M1 = 0; WVALID_M0 = 0; WVALID_M1 = 0;
    WLAST_M0 = 0; WLAST_M1 = 0; BREADY_M0 = 0; BREADY_M1 = 0;
    AWREADY_ARB = 0; WREADY_ARB = 0; BVALID_ARB = 0;
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETn = 1'b0;
    clear_inputs();
    #2;
    check("reset_ctrl", {52'b0, ctrl_act}, 64'b0);
    check("reset_bus",  bus_act, 64'b0);
    check("reset_misc", {35'b0, misc_act}, 64'b0);
    @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  // Complete whatever transaction is granted, with an always-ready slave.
  // Returns at a sample point in IDLE. Exceeding the cycle budget is a failure.
  task automatic drain(input logic a0, input logic a1);
    logic done;
    done = 1'b0;
    AWVALID_M0 = a0; AWVALID_M1 = a1;
    WVALID_M0 = 1; WVALID_M1 = 1; WLAST_M0 = 0; WLAST_M1 = 0;
    AWREADY_ARB = 1; WREADY_ARB = 1; BVALID_ARB = 1; BREADY_M0 = 1; BREADY_M1 = 1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge ACLK);
      #2;
      if (!GRANT_M0 && !GRANT_M1) done = 1'b1;
    end
    check("drain_done", {63'b0, done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESETn = 1'b0;
    clear_inputs();
    AWID_M0 = M0_ID; AWADDR_M0 = M0_ADDR; AWLEN_M0 = M0_LEN; AWSIZE_M0 = 3'd2;
    AWBURST_M0 = 2'b01; WDATA_M0 = M0_DATA; WSTRB_M0 = 4'hF;
    AWID_M1 = M1_ID; AWADDR_M1 = M1_ADDR; AWLEN_M1 = M1_LEN; AWSIZE_M1 = 3'd2;
    AWBURST_M1 = 2'b01; WDATA_M1 = M1_DATA; WSTRB_M1 = 4'h3;
    BID_ARB = S_BID; BRESP_ARB = 2'b00;

    // M0 single burst (AWLEN=3, one W stall, one B stall)
    vecs.push_back('{11'b000_0000_0000, 12'b0000_0000_0000, 32'h0,  32'h0});   // IDLE
    vecs.push_back('{11'b100_0001_0000, 12'b0000_0000_0000, 32'h0,  32'h0});   // request, no pass-through
    vecs.push_back('{11'b100_0001_0000, 12'b1100_0000_0010, M0_ADDR, 32'h0});  // ADDR handshake
    vecs.push_back('{11'b001_0000_1000, 12'b0001_0100_0010, 32'h0,  M0_DATA}); // beat 0
    vecs.push_back('{11'b001_0000_0000, 12'b0001_0000_0010, 32'h0,  M0_DATA}); // slave stall
    vecs.push_back('{11'b001_0000_1000, 12'b0001_0100_0010, 32'h0,  M0_DATA}); // beat 1
    vecs.push_back('{11'b001_0000_1000, 12'b0001_0100_0010, 32'h0,  M0_DATA}); // beat 2
    vecs.push_back('{11'b001_1000_1000, 12'b0001_1100_0010, 32'h0,  M0_DATA}); // beat 3, last
    vecs.push_back('{11'b000_0000_0100, 12'b0000_0001_0010, 32'h0,  32'h0});   // B, master not ready
    vecs.push_back('{11'b000_0000_0110, 12'b0000_0001_0110, 32'h0,  32'h0});   // B handshake
    vecs.push_back('{11'b000_0000_0000, 12'b0000_0000_0000, 32'h0,  32'h0});   // back to IDLE
    // M1 burst (AWLEN=1, WLAST never set, M0 offering W meanwhile)
    vecs.push_back('{11'b010_0000_0000, 12'b0000_0000_0000, 32'h0,  32'h0});   // request
    vecs.push_back('{11'b010_0000_0000, 12'b1000_0000_0001, M1_ADDR, 32'h0});  // ADDR, slave stall
    vecs.push_back('{11'b000_0001_0000, 12'b0010_0000_0001, M1_ADDR, 32'h0});  // AWVALID dropped, hold
    vecs.push_back('{11'b010_0001_0000, 12'b1010_0000_0001, M1_ADDR, 32'h0});  // ADDR handshake
    vecs.push_back('{11'b001_0100_1000, 12'b0001_0010_0001, 32'h0,  M1_DATA}); // beat 0
    vecs.push_back('{11'b001_0100_1000, 12'b0001_1010_0001, 32'h0,  M1_DATA}); // beat 1, forced last
    vecs.push_back('{11'b000_0000_0101, 12'b0000_0000_1101, 32'h0,  32'h0});   // B handshake
    vecs.push_back('{11'b000_0000_0000, 12'b0000_0000_0000, 32'h0,  32'h0});   // IDLE

    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge ACLK);
      {AWVALID_M0, AWVALID_M1, WVALID_M0, WLAST_M0, WVALID_M1, WLAST_M1,
       AWREADY_ARB, WREADY_ARB, BVALID_ARB, BREADY_M0, BREADY_M1} = vecs[i].in;
      #2;
      check($sformatf("vec%0d_ctrl", i), {52'b0, ctrl_act}, {52'b0, vecs[i].ctrl});
      check($sformatf("vec%0d_bus", i), bus_act, {vecs[i].addr, vecs[i].wdata});
    end
    clear_inputs();

    // Simultaneous requests, twice in a row
`ifdef AXI_WARB_RR_EN
    exp_second = 2'b01;
`else
    exp_second = 2'b10;
`endif
    do_reset();
    @(negedge ACLK);
    AWVALID_M0 = 1; AWVALID_M1 = 1;
    #2;
    check("tie_no_grant_yet", {61'b0, GRANT_M0, GRANT_M1, AWVALID_ARB}, 64'd0);
    @(negedge ACLK);
    #2;
    check("tie_first_grant", {62'b0, GRANT_M0, GRANT_M1}, 64'b10);
    drain(1'b1, 1'b1);
    @(negedge ACLK);
    #2;
    check("tie_second_grant", {62'b0, GRANT_M0, GRANT_M1}, {62'b0, exp_second});
    drain(1'b1, 1'b1);
    clear_inputs();

    // M1 requests during M0's DATA phase and waits for IDLE
    do_reset();
    @(negedge ACLK);
    AWVALID_M0 = 1; AWREADY_ARB = 1;
    @(negedge ACLK);
    #2;
    check("m0_addr_phase", {61'b0, GRANT_M0, AWVALID_ARB, AWREADY_M0}, 64'b111);
    @(negedge ACLK);
    AWVALID_M0 = 0; AWVALID_M1 = 1; WVALID_M0 = 1; WREADY_ARB = 1;
    bad = 1'b0;
    for (int b = 0; b < 4; b++) begin
      WLAST_M0 = (b == 3);
      #2;
      if (AWREADY_M1 || GRANT_M1) bad = 1'b1;
      @(negedge ACLK);
    end
    WVALID_M0 = 0; WLAST_M0 = 0; BVALID_ARB = 1; BREADY_M0 = 0;
    #2;
    if (AWREADY_M1 || GRANT_M1 || BVALID_M1) bad = 1'b1;
    check("m0_in_resp", {63'b0, BVALID_M0}, 64'd1);
    @(negedge ACLK);
    BREADY_M0 = 1;
    #2;
    if (AWREADY_M1 || GRANT_M1 || BVALID_M1) bad = 1'b1;
    check("m1_blocked", {63'b0, bad}, 64'd0);
    @(negedge ACLK);
    BVALID_ARB = 0; BREADY_M0 = 0;
    #2;
    check("idle_between", {61'b0, GRANT_M0, GRANT_M1, AWREADY_M1}, 64'd0);
    @(negedge ACLK);
    #2;
    check("m1_granted", {30'b0, GRANT_M1, AWVALID_ARB, AWADDR_ARB}, {30'b0, 2'b11, M1_ADDR});
    drain(1'b0, 1'b1);
    clear_inputs();

    // Reset asserted mid-burst after beat 2
    do_reset();
    @(negedge ACLK);
    AWVALID_M0 = 1; AWREADY_ARB = 1;
    @(negedge ACLK);
    @(negedge ACLK);
    AWVALID_M0 = 0; WVALID_M0 = 1; WREADY_ARB = 1;
    @(negedge ACLK);
    @(negedge ACLK);
    #2;
    check("pre_reset_data", {62'b0, GRANT_M0, WVALID_ARB}, 64'b11);
    ARESETn = 1'b0;
    #1;
    check("midreset_ctrl", {52'b0, ctrl_act}, 64'd0);
    check("midreset_bus", bus_act, 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    clear_inputs();
    AWVALID_M1 = 1;
    #2;
    check("post_reset_idle", {62'b0, GRANT_M0, GRANT_M1}, 64'd0);
    @(negedge ACLK);
    #2;
    check("post_reset_m1", {29'b0, GRANT_M0, GRANT_M1, AWVALID_ARB, AWADDR_ARB},
          {29'b0, 3'b011, M1_ADDR});
    drain(1'b0, 1'b1);
    clear_inputs();

    // Slave stalls AW for 5 cycles and the master stalls B for 3 cycles
    do_reset();
    BRESP_ARB = 2'b10;
    @(negedge ACLK);
    AWVALID_M0 = 1;
    @(negedge ACLK);
    for (int c = 0; c < 5; c++) begin
      #2;
      check($sformatf("aw_stall%0d", c),
            {20'b0, GRANT_M0, AWVALID_ARB, AWREADY_M0, WVALID_ARB, AWADDR_ARB, AWLEN_ARB, AWID_ARB},
            {20'b0, 4'b1100, M0_ADDR, M0_LEN, M0_ID});
      @(negedge ACLK);
    end
    AWREADY_ARB = 1;
    #2;
    check("aw_release", {62'b0, AWVALID_ARB, AWREADY_M0}, 64'b11);
    @(negedge ACLK);
    AWVALID_M0 = 0; AWREADY_ARB = 0; WVALID_M0 = 1; WREADY_ARB = 1;
    for (int b = 0; b < 4; b++) begin
      WLAST_M0 = (b == 3);
      @(negedge ACLK);
    end
    WVALID_M0 = 0; WLAST_M0 = 0; BVALID_ARB = 1; BREADY_M0 = 0;
    for (int c = 0; c < 3; c++) begin
      #2;
      check($sformatf("b_stall%0d", c),
            {54'b0, BVALID_M0, BREADY_ARB, GRANT_M0, BID_M0, BRESP_M0, BVALID_M1},
            {54'b0, 3'b101, S_BID, 2'b10, 1'b0});
      @(negedge ACLK);
    end
    BREADY_M0 = 1;
    #2;
    check("b_release", {62'b0, BVALID_M0, BREADY_ARB}, 64'b11);
    @(negedge ACLK);
    BVALID_ARB = 0; BREADY_M0 = 0;
    #2;
    check("grant_drop", {62'b0, GRANT_M0, GRANT_M1}, 64'd0);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/write_channel_arbiter.md
WRITE_CHANNEL_ARBITER -- requirements
Module: write_channel_arbiter

Interface
REQ-001 SHALL use header constants: AXI_ID_BITS, 4, ID width; AXI_ADDR_BITS, 32, address width; AXI_LEN_BITS, 4, burst length width; AXI_SIZE_BITS, 3, size width; AXI_DATA_BITS, 32, data width; AXI_STRB_BITS, 4, strobe width.
REQ-002 SHALL have these clock and reset ports: ACLK in 1, clock; ARESETn in 1, reset, asynchronous, active-low.
REQ-003 SHALL have these AW inputs from each master (x = 0, 1): AWID_Mx in ID, AWADDR_Mx in ADDR, AWLEN_Mx in LEN, AWSIZE_Mx in SIZE, AWBURST_Mx in 2, AWVALID_Mx in 1.
REQ-004 SHALL have these W inputs from each master: WDATA_Mx in DATA, WSTRB_Mx in STRB, WLAST_Mx in 1, WVALID_Mx in 1.
REQ-005 SHALL have these per-master handshake and response ports: AWREADY_Mx out 1, WREADY_Mx out 1, BID_Mx out ID, BRESP_Mx out 2, BVALID_Mx out 1, BREADY_Mx in 1.
REQ-006 SHALL have these slave-side outputs: AWID_ARB, AWADDR_ARB, AWLEN_ARB, AWSIZE_ARB, AWBURST_ARB, AWVALID_ARB, WDATA_ARB, WSTRB_ARB, WLAST_ARB, WVALID_ARB, BREADY_ARB, each out, widths per REQ-001.
REQ-007 SHALL have these slave-side inputs: AWREADY_ARB in 1, WREADY_ARB in 1, BID_ARB in ID, BRESP_ARB in 2, BVALID_ARB in 1.
REQ-008 SHALL have these status outputs: GRANT_M0 out 1, GRANT_M1 out 1, each high while that master owns the channel.

Function
REQ-009 SHALL implement a four-state FSM: IDLE, ADDR, DATA, RESP.
REQ-010 In IDLE, SHALL select a winner from AWVALID_M0/AWVALID_M1, register the grant, and enter ADDR on the next edge; with no request it SHALL stay in IDLE.
REQ-011 In IDLE, all *VALID_ARB and all master READY/BVALID outputs SHALL be 0; no AW SHALL pass combinationally in IDLE (1-cycle arbitration latency).
REQ-012 In ADDR, SHALL drive AW*_ARB from the granted master, set AWREADY_Mx = AWREADY_ARB for the granted master only, and move to DATA on AWVALID_ARB & AWREADY_ARB.
REQ-013 In DATA, SHALL drive W*_ARB from the granted master with WREADY_Mx = WREADY_ARB, and move to RESP on a handshake with WLAST_ARB = 1.
REQ-014 In DATA, SHALL count W beats (LEN width + 1); on the beat where count == AWLEN captured in ADDR, SHALL treat it as last even if WLAST is 0.
REQ-015 In RESP, SHALL route BID/BRESP/BVALID to the granted master, set BREADY_ARB = BREADY_Mx, and on BVALID_ARB & BREADY_ARB return to IDLE and release the grant.
REQ-016 The non-granted master SHALL see AWREADY = WREADY = BVALID = 0 in every state; W data offered before that master's ADDR phase completes SHALL NOT be accepted.
REQ-017 Simultaneous requests in IDLE SHALL be resolved per REQ-023; a request arriving while a grant is active SHALL wait until IDLE.
REQ-018 GRANT_Mx SHALL be high from ADDR through RESP inclusive and 0 in IDLE.
REQ-019 Deassertion of the granted master's AWVALID in ADDR SHALL NOT cancel the grant; the FSM SHALL hold in ADDR.

Reset
REQ-020 ARESETn low SHALL asynchronously force IDLE, clear both grants, set the beat count to 0, set the round-robin pointer to prefer M0, and drive every VALID/READY output to 0.
REQ-021 Reset asserted mid-burst SHALL abandon the transaction; after release, the FSM SHALL start from IDLE with no residual grant.
REQ-022 All data/address outputs SHALL read 0 in IDLE and during reset.

Configuration
REQ-023 With AXI_WARB_RR_EN defined, the arbiter SHALL use round-robin: after a transaction completes, the pointer SHALL prefer the other master. Without the macro, the arbiter SHALL use fixed priority, with M0 always winning simultaneous requests and no pointer register.

Verification
REQ-024 Single request: M0 AWADDR=0x1000, AWLEN=3, 4 W beats, BRESP=0 -> AWVALID_ARB rises 1 cycle after AWVALID_M0; 4 beats forwarded; BVALID_M0=1; GRANT_M0 drops after B handshake.
REQ-025 Simultaneous M0/M1 requests, repeated twice with RR_EN -> grant order M0, M1; without the macro -> M0, M0 while M0 keeps requesting.
REQ-026 M1 asserts AWVALID during M0's DATA phase -> AWREADY_M1 stays 0 until M0's B handshake, then M1 is granted 1 cycle after IDLE.
REQ-027 WLAST missing with AWLEN=1 -> RESP entered after the 2nd beat; WLAST_ARB = 1 on that beat.
REQ-028 ARESETn pulled low in DATA after beat 2 -> all VALID/READY outputs 0 immediately; after release, a new M1 request is granted normally.
REQ-029 Slave stalls AWREADY_ARB=0 for 5 cycles and BREADY_M0=0 for 3 cycles -> AW fields held stable; BVALID_M0 held 1; no state advance until the handshakes.
